// File: rtl/sysarr_fifo_sched.sv
// Sequencer for the systolic array's row-input FIFOs: loads one tile as N column
// beats into all row FIFOs, then drains them with a one-cycle-per-row diagonal skew.
module sysarr_fifo_sched #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            nRST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  input  logic            stall,
  output logic [N-1:0]    fifo_load,
  output logic [N*DW-1:0] fifo_load_vals,
  output logic [N-1:0]    fifo_shift,
  output logic            busy,
  output logic            tile_done,
  output logic [15:0]     tile_count
);

  localparam int LCW = (N > 1) ? $clog2(N) : 1;
  localparam int DCW = $clog2(2*N-1) + 1;
  localparam logic [LCW-1:0] LCNT_LAST = LCW'(N-1);
  localparam logic [DCW-1:0] DCNT_LAST = DCW'(2*N-2);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WRAP  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [LCW-1:0]  r_lcnt;
  logic [LCW-1:0]  w_lcnt_next;
  logic [DCW-1:0]  r_dcnt;
  logic [DCW-1:0]  w_dcnt_next;
  logic [15:0]     r_tile_count;
  logic            w_accept;
  logic            w_drain_adv;
  logic [N-1:0]    w_in_window;

  assign w_accept    = (r_state == ST_LOAD) && in_valid;
  assign w_drain_adv = (r_state == ST_DRAIN) && !stall;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state      <= ST_LOAD;
      r_lcnt       <= '0;
      r_dcnt       <= '0;
      r_tile_count <= 16'd0;
    end else begin
      r_state <= w_state_next;
      r_lcnt  <= w_lcnt_next;
      r_dcnt  <= w_dcnt_next;
      if (r_state == ST_DONE) begin
        r_tile_count <= r_tile_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_lcnt_next  = r_lcnt;
    w_dcnt_next  = r_dcnt;
    unique case (r_state)
      ST_LOAD: begin
        if (w_accept) begin
          if (r_lcnt == LCNT_LAST) begin
            w_lcnt_next  = '0;
            w_state_next = ST_WRAP;
          end else begin
            w_lcnt_next = r_lcnt + LCW'(1);
          end
        end
      end
      ST_WRAP: begin
        w_dcnt_next  = '0;
        w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A stall on the last drain step holds DRAIN; DONE only follows a real shift.
        if (!stall) begin
          if (r_dcnt == DCNT_LAST) begin
            w_dcnt_next  = '0;
            w_state_next = ST_DONE;
          end else begin
            w_dcnt_next = r_dcnt + DCW'(1);
          end
        end
      end
      ST_DONE: begin
        w_state_next = ST_LOAD;
      end
      default: begin
        w_state_next = ST_LOAD;
      end
    endcase
  end

  // Row i is live while dcnt is in [i, i+N): exactly N shifts per row per tile.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    localparam logic [DCW-1:0] WIN_LO = DCW'(gi);
    localparam logic [DCW-1:0] WIN_HI = DCW'(gi + N);
    if (gi == 0) begin : g_first
      assign w_in_window[gi] = (r_dcnt < WIN_HI);
    end else begin : g_rest
      assign w_in_window[gi] = (r_dcnt >= WIN_LO) && (r_dcnt < WIN_HI);
    end
  end

  always_comb begin
    in_ready       = 1'b0;
    busy           = 1'b1;
    tile_done      = 1'b0;
    fifo_load      = '0;
    fifo_shift     = '0;
    fifo_load_vals = in_data;
    unique case (r_state)
      ST_LOAD: begin
        in_ready  = 1'b1;
        busy      = 1'b0;
        fifo_load = w_accept ? {N{1'b1}} : {N{1'b0}};
      end
      ST_DRAIN: begin
        fifo_shift = w_drain_adv ? w_in_window : {N{1'b0}};
      end
      ST_DONE: begin
        tile_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign tile_count = r_tile_count;

endmodule
